// File: rtl/dff_bist_pkg.sv
// dff_bist_pkg: shared constants for the D flip-flop self-test engine.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - NUM_VEC, LAST_VEC, FAIL_NONE
//   - the six-entry stimulus table as {d, pr, clr} and the golden-Q rule
package dff_bist_pkg;

  localparam int         NUM_VEC   = 6;
  localparam logic [2:0] LAST_VEC  = 3'(NUM_VEC - 1);
  localparam logic [2:0] FAIL_NONE = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic d;
    logic pr;
    logic clr;
  } vec_t;

  // Listed from index 5 down to index 0 so VEC_TABLE[i] is vector i.
  // pr and clr are never both set, so the golden Q is unambiguous.
  localparam vec_t [NUM_VEC-1:0] VEC_TABLE = {
    3'b001,  // 5: D=0 clr
    3'b101,  // 4: D=1 clr
    3'b110,  // 3: D=1 pr
    3'b010,  // 2: D=0 pr
    3'b100,  // 1: D=1
    3'b000   // 0: D=0
  };

  // Vector applied while idle: clear asserted parks the DUT at Q=0.
  localparam vec_t PARK_VEC = 3'b001;

  // Clear dominates preset, preset dominates data.
  function automatic logic expected_q(input vec_t v);
    if (v.clr)     return 1'b0;
    else if (v.pr) return 1'b1;
    else           return v.d;
  endfunction

endpackage

// File: rtl/dff_bist_vec_rom.sv
// dff_bist_vec_rom: combinational lookup of one stimulus vector.
//   vec_idx in  3 : vector index 0..5; other codes return the park vector
//   d       out 1 : D for the DUT
//   pr      out 1 : preset for the DUT (active-high)
//   clr     out 1 : clear for the DUT (active-high)
//   exp_q   out 1 : golden Q the DUT must show for this vector
module dff_bist_vec_rom
  import dff_bist_pkg::*;
(
  input  logic [2:0] vec_idx,
  output logic       d,
  output logic       pr,
  output logic       clr,
  output logic       exp_q
);

  vec_t vec;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    vec = PARK_VEC;
    if (vec_idx <= LAST_VEC) vec = VEC_TABLE[vec_idx];
  end

  assign d     = vec.d;
  assign pr    = vec.pr;
  assign clr   = vec.clr;
  assign exp_q = expected_q(vec);

endmodule

// File: rtl/dff_bist.sv
// dff_bist: built-in self-test engine for the lab D flip-flop.
// Drives the six-vector sequence into the DUT, holds each vector HOLD
// cycles, compares Q/_Q on the last cycle of each hold and reports results.
//   clk      in  1     : clock, shared with the DUT
//   clr_n    in  1     : asynchronous active-low reset
//   start    in  1     : one-cycle run request (ignored while busy)
//   dut_q    in  1     : DUT Q
//   dut_qn   in  1     : DUT _Q
//   dut_d    out 1     : D to the DUT
//   dut_pr   out 1     : preset to the DUT, active-high
//   dut_clr  out 1     : clear to the DUT, active-high
//   busy     out 1     : run in progress
//   done     out 1     : results valid, held until the next start
//   pass     out 1     : done with zero failing vectors
//   err_cnt  out ERR_W : failing vector count, saturating
//   fail_idx out 3     : first failing vector, 7 if none
// HOLD must be at least 2 so the DUT has captured a vector before it is checked.
module dff_bist
  import dff_bist_pkg::*;
#(
  parameter int HOLD  = 2,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             dut_q,
  input  logic             dut_qn,
  output logic             dut_d,
  output logic             dut_pr,
  output logic             dut_clr,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_idx
);

  localparam int                HOLD_W    = $clog2(HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  logic [1:0]        state_q,    state_d;
  logic [2:0]        vec_idx_q,  vec_idx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q,  err_cnt_d;
  logic [2:0]        fail_idx_q, fail_idx_d;
  logic              exp_q_q,    exp_q_d;
  logic              dut_d_q,    dut_d_d;
  logic              dut_pr_q,   dut_pr_d;
  logic              dut_clr_q,  dut_clr_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              pass_q,     pass_d;

  logic rom_d, rom_pr, rom_clr, rom_exp;
  logic vec_fail;

  // Looks up the vector that will be applied next cycle, so the pins and
  // the golden Q are registered together with the index.
  dff_bist_vec_rom u_rom (
    .vec_idx (vec_idx_d),
    .d       (rom_d),
    .pr      (rom_pr),
    .clr     (rom_clr),
    .exp_q   (rom_exp)
  );

  // A mismatch on Q or equal Q/_Q both count as one failure for the vector.
  assign vec_fail = (dut_q != exp_q_q) || (dut_qn == dut_q);

  always_comb begin
    state_d    = state_q;
    vec_idx_d  = vec_idx_q;
    hold_cnt_d = hold_cnt_q;
    err_cnt_d  = err_cnt_q;
    fail_idx_d = fail_idx_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          vec_idx_d  = '0;
          hold_cnt_d = '0;
          err_cnt_d  = '0;
          fail_idx_d = FAIL_NONE;
        end
      end
      ST_RUN: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == HOLD_LAST) begin
          if (vec_fail) begin
            if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
            if (fail_idx_q == FAIL_NONE)    fail_idx_d = vec_idx_q;
          end
          hold_cnt_d = '0;
          if (vec_idx_q < LAST_VEC) vec_idx_d = vec_idx_q + 3'd1;
          else                      state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_RUN) begin
      dut_d_d   = rom_d;
      dut_pr_d  = rom_pr;
      dut_clr_d = rom_clr;
      exp_q_d   = rom_exp;
    end else begin
      dut_d_d   = PARK_VEC.d;
      dut_pr_d  = PARK_VEC.pr;
      dut_clr_d = PARK_VEC.clr;
      exp_q_d   = 1'b0;
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_cnt_d == '0);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      vec_idx_q  <= '0;
      hold_cnt_q <= '0;
      err_cnt_q  <= '0;
      fail_idx_q <= FAIL_NONE;
      exp_q_q    <= 1'b0;
      dut_d_q    <= PARK_VEC.d;
      dut_pr_q   <= PARK_VEC.pr;
      dut_clr_q  <= PARK_VEC.clr;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_idx_q  <= vec_idx_d;
      hold_cnt_q <= hold_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fail_idx_q <= fail_idx_d;
      exp_q_q    <= exp_q_d;
      dut_d_q    <= dut_d_d;
      dut_pr_q   <= dut_pr_d;
      dut_clr_q  <= dut_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign dut_d    = dut_d_q;
  assign dut_pr   = dut_pr_q;
  assign dut_clr  = dut_clr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_dff_bist.sv
// tb_dff_bist: self-checking bench for dff_bist. Three engines, each driving
// a behavioural flip-flop with a selectable fault: default parameters,
// HOLD=3, and ERR_W=2.
module tb_dff_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n;
  logic start_a, start_b, start_c;
  int   fault_a, fault_b, fault_c;

  logic       q_a, qn_a, d_a, pr_a, cl_a, busy_a, done_a, pass_a;
  logic [3:0] err_a;
  logic [2:0] idx_a;
  logic       q_b, qn_b, d_b, pr_b, cl_b, busy_b, done_b, pass_b;
  logic [3:0] err_b;
  logic [2:0] idx_b;
  logic       q_c, qn_c, d_c, pr_c, cl_c, busy_c, done_c, pass_c;
  logic [1:0] err_c;
  logic [2:0] idx_c;

  logic ff_a = 1'b0, ff_b = 1'b0, ff_c = 1'b0;

  // Behavioural lab flip-flop: clear wins over preset, preset over D.
  always @(posedge clk) ff_a <= cl_a ? 1'b0 : (pr_a ? 1'b1 : d_a);
  always @(posedge clk) ff_b <= cl_b ? 1'b0 : (pr_b ? 1'b1 : d_b);
  always @(posedge clk) ff_c <= cl_c ? 1'b0 : (pr_c ? 1'b1 : d_c);

  // Fault modes: 0 good, 1 Q stuck 0, 2 Q stuck 1, 3 _Q tied to Q. Returns {Q, _Q}.
  function automatic logic [1:0] fault_out(input int f, input logic ff);
    case (f)
      1:       return 2'b01;
      2:       return 2'b10;
      3:       return {ff, ff};
      default: return {ff, ~ff};
    endcase
  endfunction

  assign {q_a, qn_a} = fault_out(fault_a, ff_a);
  assign {q_b, qn_b} = fault_out(fault_b, ff_b);
  assign {q_c, qn_c} = fault_out(fault_c, ff_c);

  dff_bist u_dut_a (
    .clk(clk), .clr_n(clr_n), .start(start_a), .dut_q(q_a), .dut_qn(qn_a),
    .dut_d(d_a), .dut_pr(pr_a), .dut_clr(cl_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_cnt(err_a), .fail_idx(idx_a)
  );

  dff_bist #(.HOLD(3)) u_dut_b (
    .clk(clk), .clr_n(clr_n), .start(start_b), .dut_q(q_b), .dut_qn(qn_b),
    .dut_d(d_b), .dut_pr(pr_b), .dut_clr(cl_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_cnt(err_b), .fail_idx(idx_b)
  );

  dff_bist #(.ERR_W(2)) u_dut_c (
    .clk(clk), .clr_n(clr_n), .start(start_c), .dut_q(q_c), .dut_qn(qn_c),
    .dut_d(d_c), .dut_pr(pr_c), .dut_clr(cl_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .err_cnt(err_c), .fail_idx(idx_c)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stimulus table {D, pr, clr} for vectors 0..5.
  logic [2:0] tb_vec [6] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b101, 3'b001};

  typedef struct {
    logic [3:0] err;
    logic [2:0] idx;
    logic       pass;
  } res_t;

  typedef struct {
    int         fault;
    int         restart_at;
    logic [3:0] err;
    logic [2:0] idx;
    logic       pass;
  } case_t;

  res_t       res_q[$];
  logic [2:0] pin_q[$];
  case_t      tab[6];

  task automatic push_expect(input logic [3:0] err, input logic [2:0] idx,
                             input logic pass, input int hold);
    res_t r;
    r.err = err; r.idx = idx; r.pass = pass;
    res_q.push_back(r);
    for (int k = 0; k < 6 * hold; k++) pin_q.push_back(tb_vec[k / hold]);
  endtask

  task automatic check_result(input string tag, input logic [3:0] err,
                              input logic [2:0] idx, input logic pass, input logic done);
    res_t r;
    check({tag, " result pending"}, res_q.size() > 0, 1);
    if (res_q.size() > 0) begin
      r = res_q.pop_front();
      check({tag, " done"},     done, 1'b1);
      check({tag, " err_cnt"},  err,  r.err);
      check({tag, " fail_idx"}, idx,  r.idx);
      check({tag, " pass"},     pass, r.pass);
    end
  endtask

  // Called on a negedge. Pulses start, then checks the pins every busy cycle;
  // optionally raises start again after busy cycle restart_at.
  task automatic run_a(input string tag, input int restart_at);
    int k;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (!done_a && k < 100) begin
      if (busy_a && pin_q.size() > 0)
        check({tag, " pins"}, {d_a, pr_a, cl_a}, pin_q.pop_front());
      start_a = (k == restart_at);
      k++;
      @(negedge clk);
    end
    start_a = 1'b0;
    check({tag, " busy cycles"}, k, 12);
    check({tag, " pins parked"}, {d_a, pr_a, cl_a}, 3'b001);
    check_result(tag, err_a, idx_a, pass_a, done_a);
    pin_q.delete();
    @(negedge clk);
    check({tag, " results held"}, {busy_a, done_a}, 2'b01);
  endtask

  initial begin
    int k;
    tab[0] = '{0, -1, 4'd0, 3'd7, 1'b1};
    tab[1] = '{1, -1, 4'd3, 3'd1, 1'b0};
    tab[2] = '{2, -1, 4'd3, 3'd0, 1'b0};
    tab[3] = '{3, -1, 4'd6, 3'd0, 1'b0};
    tab[4] = '{0,  4, 4'd0, 3'd7, 1'b1};
    tab[5] = '{0, 11, 4'd0, 3'd7, 1'b1};

    clr_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    fault_a = 0; fault_b = 0; fault_c = 3;
    repeat (2) @(negedge clk);
    check("reset pins",     {d_a, pr_a, cl_a}, 3'b001);
    check("reset busy",     busy_a, 1'b0);
    check("reset done",     done_a, 1'b0);
    check("reset pass",     pass_a, 1'b0);
    check("reset err_cnt",  err_a, 4'd0);
    check("reset fail_idx", idx_a, 3'd7);
    clr_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      fault_a = tab[i].fault;
      push_expect(tab[i].err, tab[i].idx, tab[i].pass, 2);
      run_a($sformatf("case%0d", i), tab[i].restart_at);
    end

    // Reset while vector 3 is applied, with partial failures already counted.
    fault_a = 1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    check("midrun vector3 pins", {d_a, pr_a, cl_a}, 3'b110);
    check("midrun partial err",  err_a, 4'd2);
    #2 clr_n = 1'b0;
    #1;
    check("midrun rst busy",     busy_a, 1'b0);
    check("midrun rst pins",     {d_a, pr_a, cl_a}, 3'b001);
    check("midrun rst err_cnt",  err_a, 4'd0);
    check("midrun rst fail_idx", idx_a, 3'd7);
    check("midrun rst done",     done_a, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    fault_a = 0;
    push_expect(4'd0, 3'd7, 1'b1, 2);
    run_a("after reset", -1);

    // HOLD=3, good flip-flop.
    push_expect(4'd0, 3'd7, 1'b1, 3);
    pin_q.delete();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    k = 0;
    while (!done_b && k < 100) begin k++; @(negedge clk); end
    check("hold3 busy cycles", k, 18);
    check_result("hold3", err_b, idx_b, pass_b, done_b);

    // ERR_W=2, _Q tied to Q: six failures saturate at 3.
    push_expect(4'd3, 3'd0, 1'b0, 2);
    pin_q.delete();
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    k = 0;
    while (!done_c && k < 100) begin k++; @(negedge clk); end
    check("errw2 busy cycles", k, 12);
    check_result("errw2", {2'b00, err_c}, idx_c, pass_c, done_c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
